// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and sizing helpers for the PLL lock supervisor
//
// Contents:
//   state_t    - FSM state codes (PLL_RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3)
//   RETRY_W    - width of the saturating retry counter
//   cnt_width  - bit width needed by the shared down-counter

package pll_sup_pkg;

  localparam int RETRY_W = 8;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    SETTLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // The counter is loaded with N-1, so $clog2 of the largest N is enough.
  // A floor of 1 bit keeps the vector legal when every parameter is 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// rtl/pll_lock_supervisor_sync_ff.sv - multi-flop synchronizer for a single async bit
//
// Ports:
//   clk    in  - destination clock
//   rst_n  in  - asynchronous active-low reset, clears every stage to 0
//   d      in  - asynchronous input bit
//   q      out - synchronized bit, STAGES cycles behind d

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE", keep = "true" *) logic [STAGES-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else begin
      sreg <= {sreg[STAGES-2:0], d};
    end
  end

  assign q = sreg[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer and lock supervisor
//
// Ports:
//   clk           in  - reference clock (also feeds the PLL refclk)
//   reset_n       in  - asynchronous active-low reset
//   pll_locked    in  - PLL locked, asynchronous to clk
//   clear_lost    in  - one-cycle pulse clearing lock_lost
//   pll_rst       out - active-high PLL reset (registered)
//   core_reset_n  out - active-low core reset (registered)
//   lock_lost     out - sticky loss-of-lock flag
//   retry_count   out - saturating count of lock-timeout retries
//   state         out - current FSM state code

module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 1048576,
  parameter int SETTLE_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               clear_lost,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

  localparam logic [CW-1:0] RST_LOAD    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

  state_t          st;
  logic [CW-1:0]   cnt;
  logic            lk;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lk)
  );

  assign state = st;

  // pll_rst and core_reset_n are written on the transition into each state,
  // so they change on the same edge as st and never depend on inputs
  // combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st           <= PLL_RESET;
      cnt          <= RST_LOAD;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      lock_lost    <= 1'b0;
      retry_count  <= '0;
    end else begin
      // Clear first; a loss of lock in RUN below overrides it in the same cycle.
      if (clear_lost) lock_lost <= 1'b0;

      unique case (st)
        PLL_RESET: begin
          if (cnt == '0) begin
            st      <= WAIT_LOCK;
            cnt     <= TO_LOAD;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        WAIT_LOCK: begin
          // Lock is tested before timeout so a tie goes to SETTLE.
          if (lk) begin
            st  <= SETTLE;
            cnt <= SETTLE_LOAD;
          end else if (cnt == '0) begin
            st      <= PLL_RESET;
            cnt     <= RST_LOAD;
            pll_rst <= 1'b1;
            if (retry_count != RETRY_MAX) retry_count <= retry_count + RETRY_W'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        SETTLE: begin
          // A drop is tested before the final count so a tie restarts the wait.
          if (!lk) begin
            st  <= WAIT_LOCK;
            cnt <= TO_LOAD;
          end else if (cnt == '0) begin
            st           <= RUN;
            core_reset_n <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        RUN: begin
          if (!lk) begin
            st           <= PLL_RESET;
            cnt          <= RST_LOAD;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            lock_lost    <= 1'b1;
          end
        end

        default: begin
          st           <= PLL_RESET;
          cnt          <= RST_LOAD;
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor

module tb_pll_lock_supervisor;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int TO   = 20;
  localparam int SC   = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       clear_lost = 1'b0;
  logic       pll_rst;
  logic       core_reset_n;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES    (SYNC),
    .PLL_RST_CYCLES (PRC),
    .LOCK_TIMEOUT   (TO),
    .SETTLE_CYCLES  (SC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .clear_lost   (clear_lost),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus cycles spent in it, and a queue of past
  // pll_locked samples standing in for the synchronizer delay.
  int m_state;
  int m_age;
  int m_retry;
  bit m_lost;
  bit q[$];

  function automatic void m_reset();
    m_state = 0; m_age = 0; m_retry = 0; m_lost = 0;
    q = {};
    for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
  endfunction

  function automatic bit m_lk();
    return q[SYNC-1];
  endfunction

  function automatic void m_edge(input bit in, input bit clr);
    bit lk;
    bit set;
    lk = m_lk();
    set = 0;
    case (m_state)
      0: if (m_age + 1 == PRC) begin m_state = 1; m_age = 0; end else m_age++;
      1: if (lk) begin m_state = 2; m_age = 0; end
         else if (m_age + 1 == TO) begin
           m_state = 0; m_age = 0;
           if (m_retry < 255) m_retry++;
         end else m_age++;
      2: if (!lk) begin m_state = 1; m_age = 0; end
         else if (m_age + 1 == SC) begin m_state = 3; m_age = 0; end
         else m_age++;
      default: if (!lk) begin m_state = 0; m_age = 0; set = 1; end
    endcase
    if (set) m_lost = 1;
    else if (clr) m_lost = 0;
    q.push_front(in);
    void'(q.pop_back());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".pll_rst"}, 32'(pll_rst), 32'(m_state == 0));
    chk({tag, ".core_reset_n"}, 32'(core_reset_n), 32'(m_state == 3));
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
    chk({tag, ".retry_count"}, 32'(retry_count), 32'(m_retry));
  endtask

  task automatic step(input bit in, input bit clr);
    pll_locked = in;
    clear_lost = clr;
    @(posedge clk);
    m_edge(in, clr);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pll_locked = 1'b0;
    clear_lost = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic run_until(input int target, input bit in, input int budget);
    int n;
    n = 0;
    while (m_state != target && n < budget) begin
      step(in, 1'b0);
      check_model("seek");
      n++;
    end
    chk("seek_budget", 32'(m_state == target), 32'd1);
  endtask

  typedef struct {
    bit       in;
    bit       clr;
    bit [1:0] st;
    bit       prst;
    bit       crn;
    bit       lost;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit in, input bit clr, input bit [1:0] st,
                              input bit prst, input bit crn, input bit lost);
    vec_t v;
    v.in = in; v.clr = clr; v.st = st; v.prst = prst; v.crn = crn; v.lost = lost;
    tbl.push_back(v);
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    int highs;
    bit prev;
    bit cur;
    int seg;

    // Lock presented as pll_rst falls, release 2+1+8 edges later, then a
    // loss of lock in RUN and a clear_lost pulse.
    repeat (3) add(0, 0, 2'd0, 1, 0, 0);
    add(0, 0, 2'd1, 0, 0, 0);
    repeat (2) add(1, 0, 2'd1, 0, 0, 0);
    repeat (8) add(1, 0, 2'd2, 0, 0, 0);
    add(1, 0, 2'd3, 0, 1, 0);
    repeat (2) add(0, 0, 2'd3, 0, 1, 0);
    add(0, 0, 2'd0, 1, 0, 1);
    add(0, 1, 2'd0, 1, 0, 0);
    repeat (2) add(0, 0, 2'd0, 1, 0, 0);
    add(0, 0, 2'd1, 0, 0, 0);

    do_reset();
    check_model("reset");
    chk("reset.pll_rst", 32'(pll_rst), 32'd1);
    chk("reset.core_reset_n", 32'(core_reset_n), 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].in, tbl[i].clr);
      chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.pll_rst", i), 32'(pll_rst), 32'(tbl[i].prst));
      chk($sformatf("tbl%0d.core_reset_n", i), 32'(core_reset_n), 32'(tbl[i].crn));
      chk($sformatf("tbl%0d.lock_lost", i), 32'(lock_lost), 32'(tbl[i].lost));
      chk($sformatf("tbl%0d.retry", i), 32'(retry_count), 32'd0);
    end

    // Never lock: 4-cycle pll_rst pulses every 24 cycles, then saturation.
    do_reset();
    rises = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      prev = pll_rst;
      step(1'b0, 1'b0);
      check_model("nolock");
      if (!prev && pll_rst) rises++;
      if (pll_rst) highs++;
    end
    chk("nolock.rises", 32'(rises), 32'd4);
    chk("nolock.high_cycles", 32'(highs), 32'd19);
    chk("nolock.retry", 32'(retry_count), 32'd4);
    for (int i = 0; i < 6100; i++) begin
      step(1'b0, 1'b0);
      check_model("sat");
    end
    chk("sat.retry", 32'(retry_count), 32'd255);

    // Lock arriving on the timeout cycle wins.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      step(i >= 22, 1'b0);
      check_model("tie_to");
    end
    chk("tie_to.state", 32'(state), 32'd2);
    chk("tie_to.retry", 32'(retry_count), 32'd0);

    // Drop on the final settle cycle, then a full settle is required.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      step((i >= 5) && (i != 13), 1'b0);
      check_model("tie_se");
      if (i == 15) chk("tie_se.state", 32'(state), 32'd1);
      if (i == 23) chk("tie_se.core_early", 32'(core_reset_n), 32'd0);
      if (i == 24) chk("tie_se.core_rel", 32'(core_reset_n), 32'd1);
    end

    // clear_lost coincident with a fresh loss of lock: set wins.
    begin
      int n;
      n = 0;
      pll_locked = 1'b0;
      while (!(m_state == 3 && m_lk() == 0) && n < 10) begin
        step(1'b0, 1'b0);
        check_model("drop");
        n++;
      end
      step(1'b0, 1'b1);
      check_model("setwins");
      chk("setwins.lock_lost", 32'(lock_lost), 32'd1);
      step(1'b0, 1'b1);
      chk("clear.lock_lost", 32'(lock_lost), 32'd0);
    end

    // Mid-run asynchronous reset with nonzero retry_count and lock_lost set.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      check_model("pre");
    end
    run_until(3, 1'b1, 100);
    run_until(0, 1'b0, 10);
    run_until(3, 1'b1, 100);
    chk("pre.retry", 32'(retry_count), 32'd1);
    chk("pre.lock_lost", 32'(lock_lost), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async.state", 32'(state), 32'd0);
    chk("async.pll_rst", 32'(pll_rst), 32'd1);
    chk("async.core_reset_n", 32'(core_reset_n), 32'd0);
    chk("async.lock_lost", 32'(lock_lost), 32'd0);
    chk("async.retry", 32'(retry_count), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();

    // Random segments of held lock/no-lock with occasional clear pulses.
    cur = 1'b0;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        cur = $urandom_range(0, 1);
        seg = $urandom_range(1, 40);
      end
      seg--;
      step(cur, $urandom_range(0, 15) == 0);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
